// File: rtl/led_seq_ctrl.sv
// Three-LED pattern sequencer: shared step prescaler, IDLE/RUN/PAUSE mode FSM, BLINK/CHASE/BOUNCE patterns.
// Optional brightness PWM on the LED outputs is enabled by defining LED_SEQ_PWM_EN.
module led_seq_ctrl #(
  parameter int unsigned STEP_DIV = 25_000_000
`ifdef LED_SEQ_PWM_EN
  , parameter int unsigned PWM_W = 8
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode_sel,
  input  logic             mode_load,
  input  logic             pause,
`ifdef LED_SEQ_PWM_EN
  input  logic [PWM_W-1:0] duty,
`endif
  output logic [2:0]       led,
  output logic             step,
  output logic [1:0]       mode,
  output logic             running
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [1:0]  MODE_OFF    = 2'd0;
  localparam logic [1:0]  MODE_BLINK  = 2'd1;
  localparam logic [1:0]  MODE_CHASE  = 2'd2;
  localparam logic [1:0]  MODE_BOUNCE = 2'd3;
  localparam logic        DIR_UP      = 1'b0;
  localparam logic        DIR_DOWN    = 1'b1;
  localparam logic [31:0] CNT_LAST    = 32'(STEP_DIV - 1);

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  pat_q, pat_d;
  logic        dir_q, dir_d;
  logic        step_q, step_d;
  logic [1:0]  mode_q, mode_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pat_q   <= '0;
      dir_q   <= DIR_UP;
      step_q  <= 1'b0;
      mode_q  <= MODE_OFF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
      mode_q  <= mode_d;
    end
  end

  // mode_load is a single-cycle strobe with no handshake: whenever it is high at an
  // edge, mode_sel is taken on that edge, overriding pause and any step due then.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    dir_d   = dir_q;
    step_d  = 1'b0;
    mode_d  = mode_q;
    if (mode_load) begin
      mode_d = mode_sel;
      cnt_d  = '0;
      dir_d  = DIR_UP;
      case (mode_sel)
        MODE_OFF:   pat_d = 3'b000;
        MODE_BLINK: pat_d = 3'b111;
        default:    pat_d = 3'b001;
      endcase
      if (mode_sel == MODE_OFF) state_d = IDLE;
      else                      state_d = pause ? PAUSE : RUN;
    end else if (state_q == IDLE) begin
      pat_d = 3'b000;
    end else begin
      state_d = pause ? PAUSE : RUN;
      // Leaving PAUSE counts on the release edge so the held period simply resumes.
      if (!pause) begin
        if (cnt_q == CNT_LAST) begin
          cnt_d  = '0;
          step_d = 1'b1;
          case (mode_q)
            MODE_BLINK: pat_d = ~pat_q;
            MODE_CHASE: pat_d = {pat_q[1:0], pat_q[2]};
            MODE_BOUNCE: begin
              if (dir_q == DIR_UP) begin
                pat_d = {pat_q[1:0], 1'b0};
                if (pat_q[1]) dir_d = DIR_DOWN;
              end else begin
                pat_d = {1'b0, pat_q[2:1]};
                if (pat_q[1]) dir_d = DIR_UP;
              end
            end
            default: pat_d = 3'b000;
          endcase
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
    end
  end

`ifdef LED_SEQ_PWM_EN
  logic [PWM_W-1:0] pwm_cnt_q;
  logic             pwm_on_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt_q <= '0;
      pwm_on_q  <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 1'b1;
      pwm_on_q  <= (pwm_cnt_q < duty);
    end
  end

  assign led = pat_q & {3{pwm_on_q}};
`else
  assign led = pat_q;
`endif

  assign step    = step_q;
  assign mode    = mode_q;
  assign running = (state_q == RUN);

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Scoreboard bench for led_seq_ctrl (STEP_DIV=4): stimulus pushes the expected
// {cycle, mode, led} of every step pulse; a monitor pops and compares on each pulse.
module tb_led_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode_sel;
  logic       mode_load;
  logic       pause;
  logic [2:0] led;
  logic       step;
  logic [1:0] mode;
  logic       running;
`ifdef LED_SEQ_PWM_EN
  logic [7:0] duty = 8'hff;
`endif

  led_seq_ctrl #(.STEP_DIV(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode_sel  (mode_sel),
    .mode_load (mode_load),
    .pause     (pause),
`ifdef LED_SEQ_PWM_EN
    .duty      (duty),
`endif
    .led       (led),
    .step      (step),
    .mode      (mode),
    .running   (running)
  );

  // clock / cycle counter
  always #5 clk = ~clk;

  logic [31:0] cyc = '0;
  always @(posedge clk) cyc <= cyc + 32'd1;

  // scoreboard state
  logic [20:0] exp_q[$];
  logic [6:0]  probe_exp;
  logic        probe_req = 1'b0;
  string       probe_name;
  logic        done = 1'b0;
  int          n_checks = 0;
  int          n_fails = 0;
  int unsigned c_load;
  int unsigned c0;

  logic [2:0] bounce_seq [8];
  initial bounce_seq = '{3'b010, 3'b100, 3'b010, 3'b001, 3'b010, 3'b100, 3'b010, 3'b001};

  // driver tasks (called #1 after a rising edge, return #1 after a rising edge)
  task automatic load(input logic [1:0] sel);
    mode_sel  = sel;
    mode_load = 1'b1;
    @(posedge clk); #1;
    mode_load = 1'b0;
    c_load    = cyc;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_step(input int unsigned c, input logic [1:0] m, input logic [2:0] l);
    logic [31:0] cw;
    cw = c;
    exp_q.push_back({cw[15:0], m, l});
  endtask

  // expected {step, running, mode, led} at the next falling edge
  task automatic probe(input string name, input logic [6:0] e);
    probe_name = name;
    probe_exp  = e;
    probe_req  = 1'b1;
    @(negedge clk); #1;
    probe_req  = 1'b0;
    @(posedge clk); #1;
  endtask

  // monitor / final report
  initial begin
    logic [20:0] e;
    logic [20:0] got;
    forever begin
      @(negedge clk);
      if (done) begin
        n_checks++;
        if (exp_q.size() != 0) begin
          n_fails++;
          $display("FAIL leftover_steps: got %0d pending expected steps, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
      end
      if (step) begin
        n_checks++;
        got = {cyc[15:0], mode, led};
        if (exp_q.size() == 0) begin
          n_fails++;
          $display("FAIL unexpected_step: got step at cycle %0d mode=%0d led=%b, want no step",
                   cyc, mode, led);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            n_fails++;
            $display("FAIL step_check: got cycle=%0d mode=%0d led=%b, want cycle=%0d mode=%0d led=%b",
                     got[20:5], got[4:3], got[2:0], e[20:5], e[4:3], e[2:0]);
          end
        end
      end
      if (probe_req) begin
        n_checks++;
        if ({step, running, mode, led} !== probe_exp) begin
          n_fails++;
          $display("FAIL %s: got step=%b running=%b mode=%0d led=%b, want step=%b running=%b mode=%0d led=%b",
                   probe_name, step, running, mode, led,
                   probe_exp[6], probe_exp[5], probe_exp[4:3], probe_exp[2:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want normal completion");
    $fatal(1, "watchdog");
  end

  // stimulus
  initial begin
    rst       = 1'b1;
    mode_sel  = 2'd0;
    mode_load = 1'b0;
    pause     = 1'b0;
    wait_cycles(2);
    probe("reset_hold", 7'b0_0_00_000);
    rst = 1'b0;
    wait_cycles(20);
    probe("idle_20", 7'b0_0_00_000);

    // CHASE: 001 -> 010 -> 100 -> 001, step every 4 clocks
    load(2'd2);
    c0 = c_load;
    push_step(c0 + 4,  2'd2, 3'b010);
    push_step(c0 + 8,  2'd2, 3'b100);
    push_step(c0 + 12, 2'd2, 3'b001);
    probe("chase_load", 7'b0_1_10_001);
    wait_cycles(12);

    // BOUNCE for 8 steps, reloading over a running CHASE
    load(2'd3);
    c0 = c_load;
    for (int k = 0; k < 8; k++) push_step(c0 + 4 * (k + 1), 2'd3, bounce_seq[k]);
    probe("bounce_load", 7'b0_1_11_001);
    wait_cycles(32);

    // BLINK with a 10-cycle pause after 2 counted clocks
    load(2'd1);
    c0 = c_load;
    probe("blink_load", 7'b0_1_01_111);
    wait_cycles(1);
    pause = 1'b1;
    wait_cycles(4);
    probe("blink_paused", 7'b0_0_01_111);
    wait_cycles(5);
    pause = 1'b0;
    push_step(c0 + 14, 2'd1, 3'b000);
    wait_cycles(3);
    load(2'd0);
    probe("off_idle", 7'b0_0_00_000);

    // load while pause is high lands in PAUSE, then resumes from zero
    pause = 1'b1;
    load(2'd3);
    c0 = c_load;
    probe("bounce_paused_load", 7'b0_0_11_001);
    pause = 1'b0;
    push_step(c0 + 5, 2'd3, 3'b010);
    wait_cycles(4);
    load(2'd0);

    // OFF load on the same edge a CHASE step is due: no step, back to IDLE
    load(2'd2);
    wait_cycles(3);
    load(2'd0);
    probe("load_beats_step", 7'b0_0_00_000);

    // asynchronous reset mid-CHASE clears before the next clock edge
    load(2'd2);
    c0 = c_load;
    push_step(c0 + 4, 2'd2, 3'b010);
    wait_cycles(5);
    #1 rst = 1'b1;
    probe("async_rst", 7'b0_0_00_000);
    rst = 1'b0;
    wait_cycles(10);
    probe("post_rst_idle", 7'b0_0_00_000);

    done = 1'b1;
  end

endmodule
